// File: rtl/shacore_pkg.sv
// Shared SHA-256 core definitions: word type, hash state layout and byte-swap helper.
package shacore_pkg;

  localparam int WORDS_PER_HASH = 8;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } HashState;

  function automatic word_t bswap32(input word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/serial_target_check_word_le_step.sv
// One step of the serial H <= T comparison: byte-swap the incoming word and fold it
// into the running less-or-equal flag, lower words having already been folded in.
module word_le_step
  import shacore_pkg::*;
(
  input  word_t data,
  input  word_t target,
  input  logic  le_in,
  output logic  le_out
);

  word_t swapped;

  assign swapped = bswap32(data);
  // A higher word decides outright; equality defers to the lower words' verdict.
  assign le_out  = (swapped < target) | ((swapped == target) & le_in);

endmodule

// File: rtl/serial_target_check.sv
// Consumes a serialized SHA-256 state, compares the byte-swapped 256-bit hash against
// a captured difficulty target and reports hit/nonce once per hash, plus a hit counter.
module serial_target_check
  import shacore_pkg::*;
#(
  parameter int WORDS = WORDS_PER_HASH,
  parameter int LEAD  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [31:0]        nonce_i,
  input  logic [WORDS*32-1:0] target_i,
  input  logic [31:0]        data_i,
  output logic               busy_o,
  output logic               result_valid_o,
  output logic               hit_o,
  output logic [31:0]        nonce_o,
  output logic [15:0]        hits_o
);

  localparam int IW = $clog2(WORDS);
  localparam int LW = (LEAD > 2) ? $clog2(LEAD) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t              state_q, state_n;
  logic [IW-1:0]       idx_q, idx_n;
  logic [LW-1:0]       lead_q, lead_n;
  logic                le_q, le_n, le_step;
  logic [WORDS*32-1:0] target_q, target_n;
  logic [31:0]         nonce_cap_q, nonce_cap_n;
  logic                busy_n, valid_n, hit_n;
  logic [31:0]         nonce_out_n;
  logic [15:0]         hits_n;

  word_le_step u_step (
    .data   (data_i),
    .target (target_q[{idx_q, 5'd0} +: 32]),
    .le_in  (le_q),
    .le_out (le_step)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it
    // unassigned, which would otherwise infer a latch.
    state_n     = state_q;
    idx_n       = idx_q;
    lead_n      = lead_q;
    le_n        = le_q;
    target_n    = target_q;
    nonce_cap_n = nonce_cap_q;
    hit_n       = hit_o;
    nonce_out_n = nonce_o;
    hits_n      = hits_o;

    if (start_i) begin
      // A start in any state aborts whatever is in flight and begins afresh.
      target_n    = target_i;
      nonce_cap_n = nonce_i;
      idx_n       = '0;
      le_n        = 1'b1;
      lead_n      = LW'(LEAD - 2);
      state_n     = (LEAD > 1) ? S_LEAD : S_COLLECT;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_LEAD: begin
          if (lead_q == '0) state_n = S_COLLECT;
          else              lead_n  = lead_q - 1'b1;
        end
        S_COLLECT: begin
          le_n = le_step;
          if (idx_q == IW'(WORDS - 1)) begin
            state_n     = S_DONE;
            hit_n       = le_step;
            nonce_out_n = nonce_cap_q;
            if (le_step && hits_o != 16'hFFFF) hits_n = hits_o + 16'd1;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they leave the design as flops.
    busy_n  = (state_n == S_LEAD) || (state_n == S_COLLECT);
    valid_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, so the
    // order of these statements does not matter.
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      lead_q         <= '0;
      le_q           <= 1'b0;
      target_q       <= '0;
      nonce_cap_q    <= '0;
      busy_o         <= 1'b0;
      result_valid_o <= 1'b0;
      hit_o          <= 1'b0;
      nonce_o        <= '0;
      hits_o         <= '0;
    end else begin
      state_q        <= state_n;
      idx_q          <= idx_n;
      lead_q         <= lead_n;
      le_q           <= le_n;
      target_q       <= target_n;
      nonce_cap_q    <= nonce_cap_n;
      busy_o         <= busy_n;
      result_valid_o <= valid_n;
      hit_o          <= hit_n;
      nonce_o        <= nonce_out_n;
      hits_o         <= hits_n;
    end
  end

endmodule

// File: tb/tb_serial_target_check.sv
// Scoreboard bench for serial_target_check: the driver queues expected results from a
// 256-bit arithmetic model, and a negedge monitor checks every reported result and hold.
module tb_serial_target_check;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [31:0]  nonce_i;
  logic [255:0] target_i;
  logic [31:0]  data_i;
  logic         busy_o;
  logic         result_valid_o;
  logic         hit_o;
  logic [31:0]  nonce_o;
  logic [15:0]  hits_o;

  serial_target_check #(.WORDS(8), .LEAD(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .nonce_i        (nonce_i),
    .target_i       (target_i),
    .data_i         (data_i),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .hit_o          (hit_o),
    .nonce_o        (nonce_o),
    .hits_o         (hits_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        hit;
    logic [31:0] nonce;
    logic [15:0] hits;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic        h_hit = 1'b0;
  logic [31:0] h_nonce = '0;
  logic [15:0] h_hits = '0;
  logic [15:0] hits_m = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Reference: assemble the full 256-bit hash and compare as one unsigned number.
  function automatic logic ref_hit(input logic [7:0][31:0] w, input logic [255:0] t);
    logic [255:0] h;
    for (int k = 0; k < 8; k++) h[32*k +: 32] = bswap(w[k]);
    return h <= t;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("missed_result_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (result_valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_result", result_valid_o, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("result_cycle", cyc, mon_e.cyc);
          check("hit", hit_o, mon_e.hit);
          check("nonce", nonce_o, mon_e.nonce);
          check("hits", hits_o, mon_e.hits);
          check("busy_in_done", busy_o, 1'b0);
          h_hit   = mon_e.hit;
          h_nonce = mon_e.nonce;
          h_hits  = mon_e.hits;
        end
      end else begin
        check("hit_hold", hit_o, h_hit);
        check("nonce_hold", nonce_o, h_nonce);
        check("hits_hold", hits_o, h_hits);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      data_i = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic do_start(input logic [31:0] n, input logic [255:0] t);
    start_i  = 1'b1;
    nonce_i  = n;
    target_i = t;
    data_i   = $urandom;
    @(negedge clk);
    start_i  = 1'b0;
    nonce_i  = $urandom;
    target_i = {8{$urandom}};
  endtask

  task automatic run_hash(input logic [31:0] n, input logic [255:0] t, input logic [7:0][31:0] w);
    int   c0;
    exp_t e;
    c0 = cyc;
    do_start(n, t);
    for (int k = 0; k < 8; k++) begin
      data_i = w[k];
      check("busy_collect", busy_o, 1'b1);
      if (k == 7) begin
        e.hit = ref_hit(w, t);
        if (e.hit && hits_m != 16'hFFFF) hits_m = hits_m + 16'd1;
        e.nonce = n;
        e.hits  = hits_m;
        e.cyc   = c0 + 9;
        sb.push_back(e);
      end
      @(negedge clk);
    end
  endtask

  task automatic partial(input logic [31:0] n, input logic [255:0] t, input int nw);
    do_start(n, t);
    idle(nw);
  endtask

  task automatic do_reset(input logic with_start);
    rst      = 1'b1;
    start_i  = with_start;
    nonce_i  = $urandom;
    target_i = '1;
    @(posedge clk);
    h_hit   = 1'b0;
    h_nonce = '0;
    h_hits  = '0;
    hits_m  = '0;
    sb.delete();
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    check("rst_busy", busy_o, 1'b0);
    check("rst_valid", result_valid_o, 1'b0);
    check("rst_hit", hit_o, 1'b0);
    check("rst_nonce", nonce_o, 32'h0);
    check("rst_hits", hits_o, 16'h0);
  endtask

  task automatic force_saturation();
    @(posedge clk);
    #1;
    force dut.hits_o = 16'hFFFF;
    h_hits = 16'hFFFF;
    hits_m = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.hits_o;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0][31:0] w;
    logic [255:0]     t;
    int               mode;
    int               k;

    rst      = 1'b1;
    start_i  = 1'b0;
    nonce_i  = '0;
    target_i = '0;
    data_i   = '0;
    @(negedge clk);
    do_reset(1'b0);
    mon_en = 1'b1;
    idle(3);

    // Easy target: everything hits.
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    run_hash(32'h12345678, {256{1'b1}}, w);
    idle(2);

    // Equality and byte order.
    w = '0;
    run_hash(32'hA0, 256'h0, w);
    w[0] = 32'h00000001;
    run_hash(32'hA1, 256'h0, w);
    idle(1);

    // Most significant word dominates.
    t = {32'h00000100, 224'h0};
    w = {32'h00000000, {7{32'hFFFFFFFF}}};
    run_hash(32'hB0, t, w);
    w[7] = 32'h00000200;
    run_hash(32'hB1, t, w);
    idle(2);

    // Restart mid-hash: only the second hash reports.
    partial(32'h1, {256{1'b1}}, 3);
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    run_hash(32'h2, {256{1'b1}}, w);
    idle(2);

    // Reset mid-hash, then a normal hash.
    partial(32'h7, {256{1'b1}}, 4);
    do_reset(1'b0);
    idle(12);
    run_hash(32'hC0, {256{1'b1}}, w);
    idle(2);

    // Reset beats a simultaneous start.
    do_reset(1'b1);
    check("rst_start_busy", busy_o, 1'b0);
    idle(12);

    // Back-to-back hashes with no bubble.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) w[j] = $urandom;
      t = '0;
      for (int j = 0; j < 8; j++) t[32*j +: 32] = bswap(w[j]);
      if (i[0]) t[255:224] = t[255:224] - 32'd1;
      run_hash($urandom, t, w);
    end
    idle(2);

    // Saturation of the hit counter.
    force_saturation();
    run_hash(32'hD0, {256{1'b1}}, w);
    run_hash(32'hD1, 256'h0, {8{32'hFFFFFFFF}});
    idle(2);

    // Randomized hashes near and away from the target.
    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 8; j++) w[j] = $urandom;
      for (int j = 0; j < 8; j++) t[32*j +: 32] = bswap(w[j]);
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        k = $urandom_range(0, 7);
        t[32*k +: 32] = $urandom;
      end else if (mode == 2) begin
        t = {8{$urandom}};
        for (int j = 0; j < 8; j++) t[32*j +: 32] = $urandom;
      end
      run_hash($urandom, t, w);
      idle($urandom_range(0, 2));
    end

    idle(12);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
